// File: rtl/core_cache_pkg.sv
// Shared constants and types for the core-to-cache request/response bus.
// The read flag sits in the tag MSB, with a 4-bit type field directly below it.
package core_cache_pkg;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic [3:0] MEMORY = 4'b0001;
    localparam logic [3:0] MMIO   = 4'b0011;
    localparam logic [3:0] PORT   = 4'b0100;
    localparam logic [3:0] IRQ    = 4'b1110;

    // Field positions counted down from the tag MSB.
    localparam int unsigned TAG_RW_OFS      = 0;
    localparam int unsigned TAG_TYPE_HI_OFS = 1;
    localparam int unsigned TAG_TYPE_LO_OFS = 4;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the port not granted last wins.
// The pointer only moves when a grant is actually issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Reset to "port 1 granted last" so port 0 is favoured first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (|gnt) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/core_cache_arbiter.sv
// Shares one core-to-cache bus between fetch (port 0) and load/store (port 1).
// One transaction in flight; read responses are routed back to the captured owner.
module core_cache_arbiter
    import core_cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ADDRESS    = 64,
    parameter int unsigned TAG_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDRESS-1:0]    r0_req,
    input  logic [DATA_WIDTH-1:0] r0_reqdata,
    input  logic [TAG_WIDTH-1:0]  r0_reqtag,
    input  logic                  r0_reqcyc,
    output logic                  r0_reqack,
    output logic [DATA_WIDTH-1:0] r0_resp,
    output logic [TAG_WIDTH-1:0]  r0_resptag,
    output logic                  r0_respcyc,
    input  logic                  r0_respack,
    input  logic [ADDRESS-1:0]    r1_req,
    input  logic [DATA_WIDTH-1:0] r1_reqdata,
    input  logic [TAG_WIDTH-1:0]  r1_reqtag,
    input  logic                  r1_reqcyc,
    output logic                  r1_reqack,
    output logic [DATA_WIDTH-1:0] r1_resp,
    output logic [TAG_WIDTH-1:0]  r1_resptag,
    output logic                  r1_respcyc,
    input  logic                  r1_respack,
    output logic [ADDRESS-1:0]    bus_req,
    output logic [DATA_WIDTH-1:0] bus_reqdata,
    output logic [TAG_WIDTH-1:0]  bus_reqtag,
    output logic                  bus_reqcyc,
    input  logic                  bus_reqack,
    input  logic [DATA_WIDTH-1:0] bus_resp,
    input  logic [TAG_WIDTH-1:0]  bus_resptag,
    input  logic                  bus_respcyc,
    output logic                  bus_respack,
    output logic                  owner,
    output logic                  tag_err
);

    localparam int unsigned RW_BIT = TAG_WIDTH - 1 - TAG_RW_OFS;

    state_t     state;
    logic [1:0] gnt;
    logic       grant_en;
    logic       in_resp;
    logic       match;
    logic       stray;
    logic       owner_ack;

    assign grant_en = (state == IDLE) && !reset;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (grant_en),
        .req   ({r1_reqcyc, r0_reqcyc}),
        .gnt   (gnt)
    );

    assign r0_reqack = gnt[0];
    assign r1_reqack = gnt[1];

    assign in_resp   = (state == RESP);
    assign match     = in_resp && bus_respcyc && (bus_resptag == bus_reqtag);
    assign stray     = bus_respcyc && !match;
    assign owner_ack = owner ? r1_respack : r0_respack;

    // Unexpected or mismatched beats are consumed here so the bus never stalls on them.
    assign bus_respack = match ? owner_ack : bus_respcyc;

    assign r0_respcyc = match && !owner;
    assign r1_respcyc = match && owner;
    assign r0_resp    = (in_resp && !owner) ? bus_resp : '0;
    assign r0_resptag = (in_resp && !owner) ? bus_resptag : '0;
    assign r1_resp    = (in_resp && owner) ? bus_resp : '0;
    assign r1_resptag = (in_resp && owner) ? bus_resptag : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bus_req     <= '0;
            bus_reqdata <= '0;
            bus_reqtag  <= '0;
            bus_reqcyc  <= 1'b0;
            owner       <= 1'b0;
            tag_err     <= 1'b0;
        end else begin
            if (stray) begin
                tag_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        bus_req     <= gnt[1] ? r1_req : r0_req;
                        bus_reqdata <= gnt[1] ? r1_reqdata : r0_reqdata;
                        bus_reqtag  <= gnt[1] ? r1_reqtag : r0_reqtag;
                        bus_reqcyc  <= 1'b1;
                        owner       <= gnt[1];
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (bus_reqack) begin
                        bus_reqcyc <= 1'b0;
                        state      <= (bus_reqtag[RW_BIT] == READ) ? RESP : IDLE;
                    end
                end
                RESP: begin
                    if (match && owner_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_cache_arbiter.sv
// Scoreboard bench for core_cache_arbiter: stimulus pushes expected bus requests and
// responses into queues, a negedge monitor pops and compares on each DUT handshake.
module tb_core_cache_arbiter;

    localparam int DW = 512;
    localparam int AW = 64;
    localparam int TW = 13;

    logic          clk, reset;
    logic [AW-1:0] r0_req, r1_req, bus_req;
    logic [DW-1:0] r0_reqdata, r1_reqdata, bus_reqdata;
    logic [TW-1:0] r0_reqtag, r1_reqtag, bus_reqtag;
    logic          r0_reqcyc, r1_reqcyc, r0_reqack, r1_reqack;
    logic [DW-1:0] r0_resp, r1_resp, bus_resp;
    logic [TW-1:0] r0_resptag, r1_resptag, bus_resptag;
    logic          r0_respcyc, r1_respcyc, r0_respack, r1_respack;
    logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic          owner, tag_err;

    core_cache_arbiter #(.DATA_WIDTH(DW), .ADDRESS(AW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_reqdata(r0_reqdata), .r0_reqtag(r0_reqtag),
        .r0_reqcyc(r0_reqcyc), .r0_reqack(r0_reqack), .r0_resp(r0_resp),
        .r0_resptag(r0_resptag), .r0_respcyc(r0_respcyc), .r0_respack(r0_respack),
        .r1_req(r1_req), .r1_reqdata(r1_reqdata), .r1_reqtag(r1_reqtag),
        .r1_reqcyc(r1_reqcyc), .r1_reqack(r1_reqack), .r1_resp(r1_resp),
        .r1_resptag(r1_resptag), .r1_respcyc(r1_respcyc), .r1_respack(r1_respack),
        .bus_req(bus_req), .bus_reqdata(bus_reqdata), .bus_reqtag(bus_reqtag),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .owner(owner), .tag_err(tag_err)
    );

    typedef struct {
        int          port;
        logic [63:0] addr;
        logic [511:0] data;
        logic [12:0] tag;
    } bus_t;

    typedef struct {
        int          port;
        logic [511:0] data;
        logic [12:0] tag;
    } resp_t;

    bus_t  exp_bus[$];
    resp_t exp_resp[$];
    int    tests = 0;
    int    fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_bus(input int p, input logic [63:0] a, input logic [511:0] d,
                            input logic [12:0] t);
        bus_t e;
        e.port = p; e.addr = a; e.data = d; e.tag = t;
        exp_bus.push_back(e);
    endtask

    task automatic push_resp(input int p, input logic [511:0] d, input logic [12:0] t);
        resp_t e;
        e.port = p; e.data = d; e.tag = t;
        exp_resp.push_back(e);
    endtask

    // Present a request on port p and hold it until reqack; returns at posedge+1 after grant.
    task automatic do_req(input int p, input logic [63:0] a, input logic [511:0] d,
                          input logic [12:0] t);
        int n = 0;
        if (p == 0) begin
            r0_req = a; r0_reqdata = d; r0_reqtag = t; r0_reqcyc = 1'b1;
        end else begin
            r1_req = a; r1_reqdata = d; r1_reqtag = t; r1_reqcyc = 1'b1;
        end
        #1;
        while (!((p == 0) ? r0_reqack : r1_reqack) && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("reqack wait", 512'(n < 50), 512'(1));
        chk("other reqack low", 512'((p == 0) ? r1_reqack : r0_reqack), 512'(0));
        @(posedge clk); #1;
        if (p == 0) r0_reqcyc = 1'b0;
        else r1_reqcyc = 1'b0;
    endtask

    task automatic bus_accept(input int delay);
        int n = 0;
        while (!bus_reqcyc && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bus_reqcyc wait", 512'(n < 50), 512'(1));
        repeat (delay) begin
            @(posedge clk); #1;
        end
        bus_reqack = 1'b1;
        @(posedge clk); #1;
        bus_reqack = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus_reqcyc && bus_reqack) begin
                if (exp_bus.size() == 0) begin
                    chk("unexpected bus request", 512'(1), 512'(0));
                end else begin
                    bus_t e;
                    e = exp_bus.pop_front();
                    chk("bus_req", 512'(bus_req), 512'(e.addr));
                    chk("bus_reqdata", bus_reqdata, e.data);
                    chk("bus_reqtag", 512'(bus_reqtag), 512'(e.tag));
                    chk("owner", 512'(owner), 512'(e.port[0]));
                end
            end
            if ((r0_respcyc && r0_respack) || (r1_respcyc && r1_respack)) begin
                if (exp_resp.size() == 0) begin
                    chk("unexpected response", 512'(1), 512'(0));
                end else begin
                    resp_t e;
                    e = exp_resp.pop_front();
                    chk("resp port", 512'(r1_respcyc), 512'(e.port[0]));
                    chk("resp data", r1_respcyc ? r1_resp : r0_resp, e.data);
                    chk("resp tag", 512'(r1_respcyc ? r1_resptag : r0_resptag), 512'(e.tag));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        r0_req = '0; r0_reqdata = '0; r0_reqtag = '0; r0_reqcyc = 1'b0; r0_respack = 1'b0;
        r1_req = '0; r1_reqdata = '0; r1_reqtag = '0; r1_reqcyc = 1'b0; r1_respack = 1'b0;
        bus_reqack = 1'b0; bus_resp = '0; bus_resptag = '0; bus_respcyc = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst bus_reqcyc", 512'(bus_reqcyc), 512'(0));
        chk("rst bus_req", 512'(bus_req), 512'(0));
        chk("rst bus_reqdata", bus_reqdata, 512'(0));
        chk("rst bus_reqtag", 512'(bus_reqtag), 512'(0));
        chk("rst owner", 512'(owner), 512'(0));
        chk("rst tag_err", 512'(tag_err), 512'(0));
        chk("rst reqack", 512'({r0_reqack, r1_reqack}), 512'(0));
        chk("rst respcyc", 512'({r0_respcyc, r1_respcyc}), 512'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Single write from port 1
        push_bus(1, 64'h1000, 512'h5a5a, 13'h0105);
        do_req(1, 64'h1000, 512'h5a5a, 13'h0105);
        chk("wr bus_reqcyc", 512'(bus_reqcyc), 512'(1));
        chk("wr bus_req", 512'(bus_req), 512'(64'h1000));
        chk("wr owner", 512'(owner), 512'(1));
        bus_accept(0);
        chk("wr done reqcyc", 512'(bus_reqcyc), 512'(0));
        chk("wr no resp", 512'({r0_respcyc, r1_respcyc}), 512'(0));

        // Single read from port 0
        push_bus(0, 64'h2000, 512'h0, 13'h1102);
        push_resp(0, 512'hab, 13'h1102);
        do_req(0, 64'h2000, 512'h0, 13'h1102);
        bus_accept(0);
        chk("rd idle respcyc", 512'(r0_respcyc), 512'(0));
        bus_respcyc = 1'b1; bus_resptag = 13'h1102; bus_resp = 512'hab;
        #1;
        chk("rd r0_respcyc", 512'(r0_respcyc), 512'(1));
        chk("rd respack held", 512'(bus_respack), 512'(0));
        @(posedge clk); #1;
        r0_respack = 1'b1;
        #1;
        chk("rd bus_respack", 512'(bus_respack), 512'(1));
        chk("rd r1_respcyc", 512'(r1_respcyc), 512'(0));
        @(posedge clk); #1;
        bus_respcyc = 1'b0; r0_respack = 1'b0;
        #1;
        chk("rd back idle", 512'(r0_respcyc), 512'(0));
        chk("rd tag_err", 512'(tag_err), 512'(0));

        // Contention from reset: grants alternate 0,1,0,1
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        push_bus(0, 64'ha00, 512'ha, 13'h0101);
        push_bus(1, 64'hb00, 512'hb, 13'h0102);
        push_bus(0, 64'hc00, 512'hc, 13'h0103);
        push_bus(1, 64'hd00, 512'hd, 13'h0104);
        fork
            begin
                do_req(0, 64'ha00, 512'ha, 13'h0101);
                do_req(0, 64'hc00, 512'hc, 13'h0103);
            end
            begin
                do_req(1, 64'hb00, 512'hb, 13'h0102);
                do_req(1, 64'hd00, 512'hd, 13'h0104);
            end
            begin
                repeat (4) bus_accept(0);
            end
        join

        // Backpressure: bus stalls 10 cycles, port 1 waits for IDLE
        push_bus(0, 64'he00, 512'he, 13'h0301);
        push_bus(1, 64'hf00, 512'hf, 13'h0302);
        do_req(0, 64'he00, 512'he, 13'h0301);
        r1_req = 64'hf00; r1_reqdata = 512'hf; r1_reqtag = 13'h0302; r1_reqcyc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp bus_reqcyc", 512'(bus_reqcyc), 512'(1));
            chk("bp bus_req", 512'(bus_req), 512'(64'he00));
            chk("bp bus_reqtag", 512'(bus_reqtag), 512'(13'h0301));
            chk("bp r1_reqack", 512'(r1_reqack), 512'(0));
            @(posedge clk); #1;
        end
        bus_reqack = 1'b1;
        @(posedge clk); #1;
        bus_reqack = 1'b0;
        do_req(1, 64'hf00, 512'hf, 13'h0302);
        bus_accept(0);

        // Tag mismatch in RESP, then the correct tag completes
        push_bus(0, 64'h4000, 512'h0, 13'h1102);
        push_resp(0, 512'hcd, 13'h1102);
        do_req(0, 64'h4000, 512'h0, 13'h1102);
        bus_accept(0);
        chk("mm tag_err before", 512'(tag_err), 512'(0));
        bus_respcyc = 1'b1; bus_resptag = 13'h1fff; bus_resp = 512'hee; r0_respack = 1'b1;
        #1;
        chk("mm bus_respack", 512'(bus_respack), 512'(1));
        chk("mm r0_respcyc", 512'(r0_respcyc), 512'(0));
        @(posedge clk); #1;
        chk("mm tag_err set", 512'(tag_err), 512'(1));
        bus_resptag = 13'h1102; bus_resp = 512'hcd;
        #1;
        chk("mm retry respcyc", 512'(r0_respcyc), 512'(1));
        @(posedge clk); #1;
        bus_respcyc = 1'b0; r0_respack = 1'b0;
        #1;
        chk("mm tag_err sticky", 512'(tag_err), 512'(1));
        chk("mm done respcyc", 512'(r0_respcyc), 512'(0));

        // Reset mid-REQ; last grant was port 0, so only reset makes port 0 favoured again
        do_req(0, 64'h3000, 512'h3, 13'h0105);
        #1;
        chk("mid bus_reqcyc", 512'(bus_reqcyc), 512'(1));
        reset = 1'b1;
        #1;
        chk("mid rst reqcyc", 512'(bus_reqcyc), 512'(0));
        chk("mid rst tag_err", 512'(tag_err), 512'(0));
        chk("mid rst bus_req", 512'(bus_req), 512'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        push_bus(0, 64'h5000, 512'h50, 13'h0101);
        push_bus(1, 64'h6000, 512'h60, 13'h0102);
        fork
            do_req(0, 64'h5000, 512'h50, 13'h0101);
            do_req(1, 64'h6000, 512'h60, 13'h0102);
            begin
                repeat (2) bus_accept(0);
            end
        join

        // Stray response while IDLE is dropped and flagged
        bus_respcyc = 1'b1; bus_resptag = 13'h1102; bus_resp = 512'h77;
        #1;
        chk("stray bus_respack", 512'(bus_respack), 512'(1));
        chk("stray respcyc", 512'({r0_respcyc, r1_respcyc}), 512'(0));
        @(posedge clk); #1;
        bus_respcyc = 1'b0;
        chk("stray tag_err", 512'(tag_err), 512'(1));

        repeat (3) @(posedge clk);
        #1;
        chk("bus queue drained", 512'(exp_bus.size()), 512'(0));
        chk("resp queue drained", 512'(exp_resp.size()), 512'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
